// File: rtl/nibble_bus_pkg.sv
// nibble_bus_pkg: shared widths, FSM state type and helpers for the nibble bus master.
package nibble_bus_pkg;

    localparam int NIBBLE_W = 4;
    localparam int ADDR_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RTAIL = 2'd3
    } state_e;

    // Index of the final nibble of a burst.
    function automatic logic [1:0] last_idx(input int nibbles);
        return 2'(nibbles - 1);
    endfunction

endpackage

// File: rtl/nibble_bus_phy.sv
// nibble_bus_phy: tristate driver and negedge read-capture shadow for the nibble bus.
// All dual-edge behaviour of the master lives here; the FSM stays posedge-only.
module nibble_bus_phy
    import nibble_bus_pkg::*;
#(
    parameter int NIBBLES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        oe,
    input  logic [NIBBLE_W-1:0]         dout,
    input  logic                        cap_en,
    input  logic [1:0]                  cap_idx,
    output logic [NIBBLE_W*NIBBLES-1:0] shadow,
    inout  wire  [NIBBLE_W-1:0]         bus_data
);
    localparam int W = NIBBLE_W * NIBBLES;

    logic [W-1:0] shadow_q;
    logic [W-1:0] shadow_d;

    // Enable follows bus_we combinationally so release happens on the same edge memory may drive.
    assign bus_data = oe ? dout : {NIBBLE_W{1'bz}};
    assign shadow   = shadow_q;

    // Merge the bus nibble into its slot of the shadow word.
    always_comb begin
        shadow_d = shadow_q;
        for (int k = 0; k < NIBBLES; k++) begin
            shadow_d[NIBBLE_W*k +: NIBBLE_W] = (cap_en && (cap_idx == 2'(k))) ?
                bus_data : shadow_q[NIBBLE_W*k +: NIBBLE_W];
        end
    end

    // Memory drives during clk high, so the nibble is taken on the falling edge.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

endmodule

// File: rtl/nibble_bus_master.sv
// nibble_bus_master: turns one CPU word request into a little-endian burst of nibble bus cycles.
// Optional macro NIBBLE_BUS_BOUNDARY_CHK_EN adds resp_err and rejects bursts that cross 0xFF.
module nibble_bus_master
    import nibble_bus_pkg::*;
#(
    parameter int NIBBLES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [NIBBLE_W*NIBBLES-1:0] req_wdata,
    output logic                        resp_valid,
    output logic [NIBBLE_W*NIBBLES-1:0] resp_rdata,
`ifdef NIBBLE_BUS_BOUNDARY_CHK_EN
    output logic                        resp_err,
`endif
    output logic [ADDR_W-1:0]           bus_addr,
    output logic                        bus_we,
    inout  wire  [NIBBLE_W-1:0]         bus_data
);
    localparam int         W    = NIBBLE_W * NIBBLES;
    localparam logic [1:0] LAST = last_idx(NIBBLES);

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [NIBBLE_W-1:0] dout_q, dout_d;
    logic [W-1:0]        wdata_q, wdata_d;
    logic                cap_en_q, cap_en_d;
    logic [1:0]          cap_idx_q, cap_idx_d;
    logic                resp_valid_q, resp_valid_d;
    logic [W-1:0]        resp_rdata_q, resp_rdata_d;
    logic [W-1:0]        shadow_s;
    logic [1:0]          next_idx_s;
    logic [NIBBLE_W-1:0] nib_next_s;
    logic                reject_s;

`ifdef NIBBLE_BUS_BOUNDARY_CHK_EN
    logic resp_err_q, resp_err_d;
    assign reject_s = req_valid &&
        (({1'b0, req_addr} + 9'(NIBBLES - 1)) > 9'd255);
    assign resp_err = resp_err_q;
`else
    assign reject_s = 1'b0;
`endif

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign bus_addr   = addr_q;
    assign bus_we     = we_q;

    // Next-state and bus-cycle sequencing.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        we_d         = we_q;
        dout_d       = dout_q;
        wdata_d      = wdata_q;
        cap_en_d     = 1'b0;
        cap_idx_d    = cap_idx_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        next_idx_s   = cnt_q + 2'd1;
        nib_next_s   = dout_q;
        for (int k = 0; k < NIBBLES; k++) begin
            nib_next_s = (next_idx_s == 2'(k)) ? wdata_q[NIBBLE_W*k +: NIBBLE_W] : nib_next_s;
        end

        case (state_q)
            IDLE: begin
                if (reject_s) begin
                    resp_valid_d = 1'b1;
                end else if (req_valid) begin
                    wdata_d = req_wdata;
                    cnt_d   = 2'd0;
                    addr_d  = req_addr;
                    dout_d  = req_wdata[NIBBLE_W-1:0];
                    we_d    = req_write;
                    state_d = req_write ? WRITE : READ;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (cnt_q == LAST) begin
                    state_d      = IDLE;
                    we_d         = 1'b0;
                    resp_valid_d = 1'b1;
                end else begin
                    cnt_d  = next_idx_s;
                    addr_d = addr_q + 8'd1;
                    dout_d = nib_next_s;
                end
            end
            READ: begin
                // Nibble cnt_q appears on the bus during the next cycle's high phase.
                cap_en_d  = 1'b1;
                cap_idx_d = cnt_q;
                if (cnt_q == LAST) begin
                    state_d = RTAIL;
                end else begin
                    cnt_d  = next_idx_s;
                    addr_d = addr_q + 8'd1;
                end
            end
            RTAIL: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                resp_rdata_d = shadow_s;
            end
            default: begin
                state_d = IDLE;
                we_d    = 1'b0;
            end
        endcase
    end

`ifdef NIBBLE_BUS_BOUNDARY_CHK_EN
    // Only completions issued from IDLE are boundary rejects.
    always_comb begin
        resp_err_d = resp_valid_d ? (state_q == IDLE) : resp_err_q;
    end

    // Error flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_err_q <= 1'b0;
        end else begin
            resp_err_q <= resp_err_d;
        end
    end
`endif

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            addr_q       <= 8'h00;
            we_q         <= 1'b0;
            dout_q       <= 4'h0;
            wdata_q      <= '0;
            cap_en_q     <= 1'b0;
            cap_idx_q    <= 2'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            dout_q       <= dout_d;
            wdata_q      <= wdata_d;
            cap_en_q     <= cap_en_d;
            cap_idx_q    <= cap_idx_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    nibble_bus_phy #(
        .NIBBLES (NIBBLES)
    ) u_phy (
        .clk      (clk),
        .rst      (rst),
        .oe       (we_q),
        .dout     (dout_q),
        .cap_en   (cap_en_q),
        .cap_idx  (cap_idx_q),
        .shadow   (shadow_s),
        .bus_data (bus_data)
    );

endmodule

// File: tb/tb_nibble_bus_master.sv
// tb_nibble_bus_master: randomized bench with a 256-nibble bus memory and an array-based reference model.
module tb_nibble_bus_master;
    localparam int N = 2;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [7:0]   req_addr;
    logic [W-1:0] req_wdata;
    logic         resp_valid;
    logic [W-1:0] resp_rdata;
    logic [7:0]   bus_addr;
    logic         bus_we;
    wire  [3:0]   bus_data;
`ifdef NIBBLE_BUS_BOUNDARY_CHK_EN
    logic         resp_err;
`endif

    logic [3:0]  mem     [256];
    logic [3:0]  exp_mem [256];
    logic [7:0]  rd_addr = 8'h00;
    logic        mem_hi  = 1'b0;
    logic        mem_oe;
    logic [3:0]  mem_dout;
    logic [15:0] last_rdata = 16'h0000;
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          clash_cnt = 0;
    int          acc_cnt = 0;

    nibble_bus_master #(.NIBBLES(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
`ifdef NIBBLE_BUS_BOUNDARY_CHK_EN
        .resp_err   (resp_err),
`endif
        .bus_addr   (bus_addr),
        .bus_we     (bus_we),
        .bus_data   (bus_data)
    );

    always #5 clk = ~clk;

    // Bus memory: samples address at posedge, drives during clk high (plus a short hold), writes at negedge.
    assign mem_oe   = mem_hi && !bus_we;
    assign mem_dout = mem[rd_addr];
    assign bus_data = mem_oe ? mem_dout : 4'bzzzz;

    always @(posedge clk) begin
        rd_addr = bus_addr;
        mem_hi  = 1'b1;
    end

    always @(negedge clk) begin
        if (bus_we) mem[bus_addr] = bus_data;
        if (mem_oe && (bus_data != mem_dout)) clash_cnt++;
        #1 mem_hi = 1'b0;
    end

    always @(posedge clk) begin
        if (req_valid && req_ready && !rst) acc_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic bit model_reject(input logic [7:0] a);
`ifdef NIBBLE_BUS_BOUNDARY_CHK_EN
        return (int'(a) + N - 1) > 255;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [15:0] model_read(input logic [7:0] a);
        logic [15:0] r = 16'h0000;
        for (int i = 0; i < N; i++) r = r | (16'(exp_mem[8'(int'(a) + i)]) << (4 * i));
        return r;
    endfunction

    // Issue one request (called #1 after a posedge); returns data, latency, and bus observations.
    task automatic run_req(input logic wr, input logic [7:0] a, input logic [15:0] d,
                           output logic [15:0] rd, output int lat, output logic b2b, output logic we_seen);
        int n = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d[W-1:0];
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("req_ready_wait", 32'(req_ready), 32'd1);
        b2b = resp_valid;
        @(posedge clk); #1;
        req_valid = 1'b0;
        we_seen = bus_we;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            we_seen |= bus_we;
            lat++;
        end
        check_eq("resp_valid_wait", 32'(resp_valid), 32'd1);
        rd = 16'(resp_rdata);
    endtask

    task automatic do_op(input string tag, input logic wr, input logic [7:0] a, input logic [15:0] d);
        logic [15:0] rd, exp_rd;
        int          lat;
        logic        b2b, we_seen;
        bit          rej;
        rej    = model_reject(a);
        exp_rd = (wr || rej) ? last_rdata : model_read(a);
        run_req(wr, a, d, rd, lat, b2b, we_seen);
        check_eq({tag, "_lat"}, 32'(lat), rej ? 32'd1 : (wr ? 32'(N) : 32'(N + 1)));
        check_eq({tag, "_rdata"}, 32'(rd), 32'(exp_rd));
        check_eq({tag, "_we_seen"}, 32'(we_seen), 32'(wr && !rej));
`ifdef NIBBLE_BUS_BOUNDARY_CHK_EN
        check_eq({tag, "_err"}, 32'(resp_err), 32'(rej));
`endif
        if (wr && !rej) begin
            for (int i = 0; i < N; i++) exp_mem[8'(int'(a) + i)] = d[4*i +: 4];
        end
        for (int i = 0; i < N; i++) begin
            check_eq({tag, "_mem"}, 32'(mem[8'(int'(a) + i)]), 32'(exp_mem[8'(int'(a) + i)]));
        end
        last_rdata = exp_rd;
    endtask

    initial begin
        logic [15:0] rd;
        int          lat, n, base;
        logic        b2b, we_seen, seen, rdy_seen;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 4'($urandom);
            exp_mem[i] = mem[i];
        end
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_addr", 32'(bus_addr), 32'h0);
        check_eq("rst_we", 32'(bus_we), 32'd0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_rdata", 32'(resp_rdata), 32'h0);
        @(negedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases.
        do_op("wr_a5", 1'b1, 8'h10, 16'h00A5);
        check_eq("wr_a5_lo", 32'(mem[8'h10]), 32'h5);
        check_eq("wr_a5_hi", 32'(mem[8'h11]), 32'hA);
        @(posedge clk); #1;
        check_eq("resp_pulse", 32'(resp_valid), 32'd0);

        mem[8'h20] = 4'h3; exp_mem[8'h20] = 4'h3;
        mem[8'h21] = 4'hC; exp_mem[8'h21] = 4'hC;
        do_op("rd_c3", 1'b0, 8'h20, 16'h0000);
        check_eq("rd_c3_data", 32'(resp_rdata), 32'hC3);

        do_op("wrap", 1'b1, 8'hFF, 16'h007E);

        do_op("b2b_wr", 1'b1, 8'h40, 16'h0012);
        run_req(1'b0, 8'h40, 16'h0000, rd, lat, b2b, we_seen);
        check_eq("b2b_overlap", 32'(b2b), 32'd1);
        check_eq("b2b_rdata", 32'(rd), 32'h12);
        last_rdata = 16'h0012;

        // Reset during a read burst.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h30;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check_eq("mid_rst_ready", 32'(req_ready), 32'd1);
        check_eq("mid_rst_addr", 32'(bus_addr), 32'h0);
        check_eq("mid_rst_we", 32'(bus_we), 32'd0);
        check_eq("mid_rst_rdata", 32'(resp_rdata), 32'h0);
        @(negedge clk); #2 rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen |= resp_valid;
        end
        check_eq("mid_rst_no_resp", 32'(seen), 32'd0);
        last_rdata = 16'h0000;
        do_op("after_rst", 1'b0, 8'h30, 16'h0000);

        // req_valid held high through a burst.
        base = acc_cnt; rdy_seen = 1'b0; n = 0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h80; req_wdata = W'(16'h005A);
        @(posedge clk); #1;
        while (!resp_valid && n < 10) begin
            rdy_seen |= req_ready;
            @(posedge clk); #1;
            n++;
        end
        req_valid = 1'b0;
        exp_mem[8'h80] = 4'hA; exp_mem[8'h81] = 4'h5;
        check_eq("bp_resp", 32'(resp_valid), 32'd1);
        check_eq("bp_ready_low", 32'(rdy_seen), 32'd0);
        check_eq("bp_accepts", 32'(acc_cnt - base), 32'd1);
        check_eq("bp_mem0", 32'(mem[8'h80]), 32'hA);
        check_eq("bp_mem1", 32'(mem[8'h81]), 32'h5);

        // Randomized traffic against the array model.
        for (int k = 0; k < 40; k++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
            do_op("rnd", 1'($urandom_range(0, 1)), a, 16'($urandom));
        end

        check_eq("no_contention", 32'(clash_cnt), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
